// File: rtl/logistic_iter.sv
// Fixed-point logistic-map iterator: once per period produces N_OSC iterates
// x <- r*x*(1-x) using one shared LSB-first shift-add multiplier, then steps r.
module logistic_iter #(
  parameter int unsigned N_OSC    = 8,
  parameter int unsigned ITER_LEN = 15361,
  parameter int unsigned FRAC     = 16,
  parameter int unsigned R_INC    = 2,
  parameter int unsigned R_START  = 196608,
  parameter int unsigned X_SEED   = 32768
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [FRAC-1:0]            x_out,
  output logic [$clog2(N_OSC)-1:0]   x_idx,
  output logic                       x_valid,
  output logic [FRAC+1:0]            r_out,
  output logic                       overrun
);

  localparam int unsigned AW  = 2*FRAC + 2;
  localparam int unsigned BW  = FRAC + 2;
  localparam int unsigned CW  = $clog2(ITER_LEN);
  localparam int unsigned KW  = $clog2(N_OSC);
  localparam int unsigned BCW = $clog2(FRAC + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL1 = 2'd1;
  localparam logic [1:0] S_MUL2 = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  localparam logic [FRAC-1:0] SEED_V    = FRAC'(X_SEED);
  localparam logic [FRAC+1:0] RSTART_V  = (FRAC+2)'(R_START);
  localparam logic [FRAC+2:0] RINC_V    = (FRAC+3)'(R_INC);
  localparam logic [FRAC+2:0] R_LIMIT   = {3'b100, {FRAC{1'b0}}};
  localparam logic [FRAC:0]   ONE       = {1'b1, {FRAC{1'b0}}};
  localparam logic [CW-1:0]   CNT_LAST  = CW'(ITER_LEN - 1);
  localparam logic [KW-1:0]   K_LAST    = KW'(N_OSC - 1);
  localparam logic [BCW-1:0]  B1_LAST   = BCW'(FRAC);
  localparam logic [BCW-1:0]  B2_LAST   = BCW'(FRAC + 1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [AW-1:0]   a_q, a_d;
  logic [BW-1:0]   b_q, b_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [FRAC-1:0] x_q, x_d;
  logic [FRAC+1:0] r_q, r_d;
  logic [FRAC-1:0] x_out_q, x_out_d;
  logic [KW-1:0]   x_idx_q, x_idx_d;
  logic            x_valid_q, x_valid_d;
  logic            overrun_q, overrun_d;

  logic            tick;
  logic [AW-1:0]   acc_step;
  logic [FRAC-1:0] y_sat;
  logic [FRAC-1:0] res;
  logic [FRAC+2:0] r_sum;
  logic [FRAC+1:0] r_next;

  always_comb begin
    tick     = (cnt_q == '0);
    acc_step = b_q[0] ? (acc_q + a_q) : acc_q;
    // acc_q holds the full r*t product once MUL2 has finished
    y_sat    = (acc_q[AW-1:2*FRAC] != '0) ? '1 : acc_q[2*FRAC-1:FRAC];
    res      = (y_sat == '0) ? SEED_V : y_sat;
    r_sum    = {1'b0, r_q} + RINC_V;
    r_next   = (r_sum >= R_LIMIT) ? RSTART_V : r_sum[FRAC+1:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    k_d       = k_q;
    bcnt_d    = bcnt_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    x_d       = x_q;
    r_d       = r_q;
    x_out_d   = x_out_q;
    x_idx_d   = x_idx_q;
    x_valid_d = 1'b0;
    overrun_d = overrun_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          k_d     = '0;
          a_d     = AW'(x_q);
          b_d     = {1'b0, ONE - {1'b0, x_q}};
          acc_d   = '0;
          bcnt_d  = '0;
          state_d = S_MUL1;
        end
      end
      S_MUL1: begin
        acc_d  = acc_step;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == B1_LAST) begin
          a_d     = AW'(acc_step[2*FRAC-1:FRAC]);
          b_d     = r_q;
          acc_d   = '0;
          bcnt_d  = '0;
          state_d = S_MUL2;
        end
      end
      S_MUL2: begin
        acc_d  = acc_step;
        a_d    = a_q << 1;
        b_d    = b_q >> 1;
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == B2_LAST) begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        x_d       = res;
        x_out_d   = res;
        x_idx_d   = k_q;
        x_valid_d = 1'b1;
        if (k_q == K_LAST) begin
          r_d     = r_next;
          state_d = S_IDLE;
        end else begin
          k_d     = k_q + 1'b1;
          a_d     = AW'(res);
          b_d     = {1'b0, ONE - {1'b0, res}};
          acc_d   = '0;
          bcnt_d  = '0;
          state_d = S_MUL1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      k_q       <= '0;
      bcnt_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      x_q       <= SEED_V;
      r_q       <= RSTART_V;
      x_out_q   <= '0;
      x_idx_q   <= '0;
      x_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      bcnt_q    <= bcnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      r_q       <= r_d;
      x_out_q   <= x_out_d;
      x_idx_q   <= x_idx_d;
      x_valid_q <= x_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign x_out   = x_out_q;
  assign x_idx   = x_idx_q;
  assign x_valid = x_valid_q;
  assign r_out   = r_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_logistic_iter.sv
// Bench for logistic_iter: four parameterisations run side by side against a
// schedule-level arithmetic model, with randomly timed asynchronous resets.
module tb_logistic_iter;

  localparam int P = 36;

  typedef struct {
    int     n;
    int     len;
    longint rinc;
    longint rstart;
    longint seed;
  } cfg_t;

  typedef struct {
    bit     act;
    int     start;
    longint x;
    longint r;
    longint xo;
    longint idx;
    bit     v;
    bit     ov;
  } mdl_t;

  logic        clk;
  logic        reset;
  logic [15:0] xo [4];
  logic [2:0]  xi [4];
  logic        xv [4];
  logic [17:0] ro [4];
  logic        ov [4];

  cfg_t cfg [4];
  mdl_t m   [4];

  int n_total;
  int n_bad;
  int pulses0;
  bit prev_v0;

  logistic_iter #(.N_OSC(8), .ITER_LEN(15361), .FRAC(16), .R_INC(2),
                  .R_START(196608), .X_SEED(32768)) u_dflt (
    .clk(clk), .reset(reset), .x_out(xo[0]), .x_idx(xi[0]),
    .x_valid(xv[0]), .r_out(ro[0]), .overrun(ov[0]));

  logistic_iter #(.N_OSC(8), .ITER_LEN(300), .FRAC(16), .R_INC(2),
                  .R_START(262138), .X_SEED(32768)) u_wrap (
    .clk(clk), .reset(reset), .x_out(xo[1]), .x_idx(xi[1]),
    .x_valid(xv[1]), .r_out(ro[1]), .overrun(ov[1]));

  logistic_iter #(.N_OSC(8), .ITER_LEN(300), .FRAC(16), .R_INC(2),
                  .R_START(196608), .X_SEED(1)) u_seed (
    .clk(clk), .reset(reset), .x_out(xo[2]), .x_idx(xi[2]),
    .x_valid(xv[2]), .r_out(ro[2]), .overrun(ov[2]));

  logistic_iter #(.N_OSC(8), .ITER_LEN(100), .FRAC(16), .R_INC(2),
                  .R_START(196608), .X_SEED(32768)) u_ovr (
    .clk(clk), .reset(reset), .x_out(xo[3]), .x_idx(xi[3]),
    .x_valid(xv[3]), .r_out(ro[3]), .overrun(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint next_x(longint x, longint r, longint seed);
    longint t, f, y;
    t = (x * (65536 - x)) / 65536;
    f = (r * t) / 65536;
    y = (f > 65535) ? 65535 : f;
    return (y == 0) ? seed : y;
  endfunction

  // Expected outputs after edge e, derived from the iteration schedule
  function automatic mdl_t mstep(mdl_t mi, cfg_t c, int e);
    mdl_t o;
    int   k;
    o   = mi;
    o.v = 1'b0;
    if (e % c.len == 0) begin
      if (o.act) o.ov = 1'b1;
      else begin
        o.act   = 1'b1;
        o.start = e;
        return o;
      end
    end
    if (o.act && e > o.start && (e - o.start) % P == 0) begin
      k     = (e - o.start) / P - 1;
      o.x   = next_x(o.x, o.r, c.seed);
      o.xo  = o.x;
      o.idx = k;
      o.v   = 1'b1;
      if (k == c.n - 1) begin
        o.r   = (o.r + c.rinc >= 4 * 65536) ? c.rstart : o.r + c.rinc;
        o.act = 1'b0;
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m[i].act = 1'b0; m[i].start = 0; m[i].x = cfg[i].seed; m[i].r = cfg[i].rstart;
      m[i].xo = 0; m[i].idx = 0; m[i].v = 1'b0; m[i].ov = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string why);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("%s_x_out%0d", why, i), 64'(xo[i]), 64'd0);
      check_val($sformatf("%s_x_idx%0d", why, i), 64'(xi[i]), 64'd0);
      check_val($sformatf("%s_x_valid%0d", why, i), 64'(xv[i]), 64'd0);
      check_val($sformatf("%s_r_out%0d", why, i), 64'(ro[i]), 64'(cfg[i].rstart));
      check_val($sformatf("%s_overrun%0d", why, i), 64'(ov[i]), 64'd0);
    end
  endtask

  task automatic run_edges(input int nedges);
    logic [63:0] c_tab [3];
    logic [63:0] r_tab [4];
    c_tab[0] = 64'hC000; c_tab[1] = 64'h9000; c_tab[2] = 64'hBD00;
    r_tab[0] = 64'h3FFFA; r_tab[1] = 64'h3FFFC; r_tab[2] = 64'h3FFFE; r_tab[3] = 64'h3FFFA;
    prev_v0 = 1'b0;
    pulses0 = 0;
    for (int e = 0; e < nedges; e++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        m[i] = mstep(m[i], cfg[i], e);
        check_val($sformatf("valid%0d_e%0d", i, e), 64'(xv[i]), 64'(m[i].v));
        check_val($sformatf("x_out%0d_e%0d", i, e), 64'(xo[i]), 64'(m[i].xo));
        check_val($sformatf("x_idx%0d_e%0d", i, e), 64'(xi[i]), 64'(m[i].idx));
        check_val($sformatf("r_out%0d_e%0d", i, e), 64'(ro[i]), 64'(m[i].r));
        check_val($sformatf("overrun%0d_e%0d", i, e), 64'(ov[i]), 64'(m[i].ov));
      end
      if (e == 36 || e == 72 || e == 108) begin
        check_val($sformatf("dir_x_e%0d", e), 64'(xo[0]), c_tab[e/36 - 1]);
        check_val($sformatf("dir_idx_e%0d", e), 64'(xi[0]), 64'(e/36 - 1));
      end
      if (e == 287) check_val("dir_r_before", 64'(ro[0]), 64'h30000);
      if (e == 288) check_val("dir_r_after", 64'(ro[0]), 64'h30002);
      if (e == 99)  check_val("dir_ovr_pre", 64'(ov[3]), 64'd0);
      if (e == 100) check_val("dir_ovr_set", 64'(ov[3]), 64'd1);
      if (e == 336) check_val("dir_ovr_next_start", 64'(xv[3]), 64'd1);
      if (e % 300 == 1 && e < 1200) check_val($sformatf("dir_wrap_e%0d", e), 64'(ro[1]), r_tab[e/300]);
      if (xv[2]) check_val($sformatf("seed_x_e%0d", e), 64'(xo[2]), 64'd1);
      if (xv[0]) begin
        pulses0++;
        check_val($sformatf("x_nonzero_e%0d", e), 64'(xo[0] == 16'd0), 64'd0);
        check_val($sformatf("no_back2back_e%0d", e), 64'(prev_v0), 64'd0);
      end
      check_val($sformatf("r_below4_e%0d", e), 64'(ro[0] < 18'h3FFFF + 18'h0), 64'd1);
      prev_v0 = xv[0];
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    cfg[0] = '{n: 8, len: 15361, rinc: 2, rstart: 196608, seed: 32768};
    cfg[1] = '{n: 8, len: 300,   rinc: 2, rstart: 262138, seed: 32768};
    cfg[2] = '{n: 8, len: 300,   rinc: 2, rstart: 196608, seed: 1};
    cfg[3] = '{n: 8, len: 100,   rinc: 2, rstart: 196608, seed: 32768};
    model_reset();

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    run_edges(2 * 15361);
    check_val("pulse_count_2periods", 64'(pulses0), 64'd16);

    for (int t = 0; t < 3; t++) begin
      int len;
      len = (t == 0) ? 59 : int'($urandom_range(40, 700));
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run_edges(len);
      #2;
      reset = 1'b1;
      #1;
      check_reset_vals($sformatf("async%0d", t));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      run_edges(120);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
